adder_slice_sched: RTL and testbench

- Sequencer/arbiter that time-shares one combinational 5-bit approximate adder slice among NREQ requesters. The slice has 11 inputs (a[4:0], b[4:0], cin) and 6 outputs (sum[4:0], cout).
- Each accepted request is a W = 5*NSLICE bit addition. It runs over NSLICE consecutive cycles, least-significant slice first, with the carry chained through a register.
- Sits between the requesting datapath units and the synthesized approximate slice, which is instantiated outside this block.

---
 rtl/adder_slice_sched_if.sv | 30 +++
 rtl/adder_slice_sched.sv | 154 +++++++++++++++
 tb/tb_adder_slice_sched.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_slice_sched_if.sv
// Request/response bundle for adder_slice_sched.
// master: requesting datapath side; slave: the scheduler.
interface adder_slice_sched_if #(
   parameter int NREQ   = 2,
   parameter int NSLICE = 4
);
   localparam int W   = 5 * NSLICE;
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a;
   logic [NREQ*W-1:0] req_b;
   logic [NREQ-1:0]   req_cin;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              rsp_cout;

   modport master (
      output req_valid, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );

   modport slave (
      input  req_valid, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
   );
endinterface

// File: rtl/adder_slice_sched.sv
// adder_slice_sched: round-robin scheduler that time-shares one external
// 5-bit adder slice. Each accepted W = 5*NSLICE bit addition runs LSB slice
// first over NSLICE cycles with the carry held in a register.
// Optional build macro ADDER_SLICE_ERR_MON_EN adds an exact reference adder,
// a per-response rsp_err flag and a saturating 16-bit err_cnt.
module adder_slice_sched #(
   parameter int NREQ   = 2,
   parameter int NSLICE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   adder_slice_sched_if.slave bus,
   output logic [4:0] sl_a,
   output logic [4:0] sl_b,
   output logic       sl_cin,
   input  logic [5:0] sl_sum
`ifdef ADDER_SLICE_ERR_MON_EN
   ,
   output logic        rsp_err,
   output logic [15:0] err_cnt
`endif
);
   localparam int W   = 5 * NSLICE;
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int IXW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int CW  = IDW + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state_reg;
   logic [IDW-1:0] rr_ptr_reg;
   logic [IDW-1:0] id_reg;
   logic [IXW-1:0] idx_reg;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic           cin_reg;
   logic [W-1:0]   sum_reg;
   logic           carry_reg;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gnt_id;
   logic            gnt_any;
   logic [CW-1:0]   cand;

   // Per-requester operand views of the packed request buses
   logic [W-1:0] a_arr [NREQ];
   logic [W-1:0] b_arr [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = bus.req_a[gi*W +: W];
      assign b_arr[gi] = bus.req_b[gi*W +: W];
   end

   // Round-robin search: first valid requester at or above rr_ptr, wrapping
   always_comb begin
      grant   = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_reg} + CW'(k);
         if (cand >= CW'(NREQ)) begin
            cand = cand - CW'(NREQ);
         end
         if (!gnt_any && bus.req_valid[cand[IDW-1:0]]) begin
            grant[cand[IDW-1:0]] = 1'b1;
            gnt_id               = cand[IDW-1:0];
            gnt_any              = 1'b1;
         end
      end
   end

   // Grants are only offered while idle and out of reset
   assign bus.req_ready = (state_reg == IDLE && rst_n) ? grant : '0;
   assign bus.rsp_valid = (state_reg == DONE);
   assign bus.rsp_id    = id_reg;
   assign bus.rsp_sum   = sum_reg;
   assign bus.rsp_cout  = carry_reg;

   // Slice operands are only live while an operation is running
   always_comb begin
      sl_a   = '0;
      sl_b   = '0;
      sl_cin = 1'b0;
      if (state_reg == RUN) begin
         sl_a   = a_reg[5*idx_reg +: 5];
         sl_b   = b_reg[5*idx_reg +: 5];
         sl_cin = (idx_reg == '0) ? cin_reg : carry_reg;
      end
   end

   // Accept, slice sequencing and response hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         id_reg     <= '0;
         idx_reg    <= '0;
         a_reg      <= '0;
         b_reg      <= '0;
         cin_reg    <= 1'b0;
         sum_reg    <= '0;
         carry_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (gnt_any) begin
                  a_reg      <= a_arr[gnt_id];
                  b_reg      <= b_arr[gnt_id];
                  cin_reg    <= bus.req_cin[gnt_id];
                  id_reg     <= gnt_id;
                  idx_reg    <= '0;
                  rr_ptr_reg <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               sum_reg[5*idx_reg +: 5] <= sl_sum[4:0];
               carry_reg               <= sl_sum[5];
               idx_reg                 <= idx_reg + 1'b1;
               if (idx_reg == IXW'(NSLICE-1)) begin
                  state_reg <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

`ifdef ADDER_SLICE_ERR_MON_EN
   logic [W:0]  exact_sum;
   logic [15:0] err_cnt_reg;

   assign exact_sum = {1'b0, a_reg} + {1'b0, b_reg} + {{W{1'b0}}, cin_reg};
   assign rsp_err   = (state_reg == DONE) && ({carry_reg, sum_reg} != exact_sum);
   assign err_cnt   = err_cnt_reg;

   // Saturating count of erroneous responses, bumped on the handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_cnt_reg <= '0;
      end else if (rsp_err && bus.rsp_ready && err_cnt_reg != 16'hFFFF) begin
         err_cnt_reg <= err_cnt_reg + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_adder_slice_sched.sv
// Testbench for adder_slice_sched: randomized and directed requests, an
// arithmetic reference model, and a scoreboard drained by a response monitor.
// Build with ADDER_SLICE_ERR_MON_EN to use an approximate slice (sum[0]
// forced low) and to check rsp_err / err_cnt.
module tb_adder_slice_sched;
   localparam int NREQ   = 2;
   localparam int NSLICE = 4;
   localparam int W      = 5 * NSLICE;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] sl_a;
   logic [4:0] sl_b;
   logic       sl_cin;
   logic [5:0] sl_sum;
`ifdef ADDER_SLICE_ERR_MON_EN
   logic        rsp_err;
   logic [15:0] err_cnt;
`endif

   int total = 0;
   int bad   = 0;

   adder_slice_sched_if #(.NREQ(NREQ), .NSLICE(NSLICE)) bus ();

   adder_slice_sched #(.NREQ(NREQ), .NSLICE(NSLICE)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .sl_a   (sl_a),
      .sl_b   (sl_b),
      .sl_cin (sl_cin),
      .sl_sum (sl_sum)
`ifdef ADDER_SLICE_ERR_MON_EN
      ,
      .rsp_err(rsp_err),
      .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   // External slice model
   always_comb begin
      sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {5'd0, sl_cin};
`ifdef ADDER_SLICE_ERR_MON_EN
      sl_sum[0] = 1'b0;
`endif
   end

   typedef struct {
      int           id;
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
   } exp_t;

   exp_t sbq[$];
   int   ph = 0;
   int   run_k = 0;
   int   rr_m = 0;
   int   acc_cnt = 0;
   int   rsp_cnt = 0;
   int   err_m = 0;
   logic [W-1:0] cur_a;
   logic [W-1:0] cur_b;
   logic         cur_cin;
   logic         rstchk = 1'b0;
   logic         dir_en = 1'b0;
   logic [W-1:0] dir_sum = '0;
   logic         dir_cout = 1'b0;
   logic         rand_bp = 1'b0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NREQ-1:0] rr_pick(logic [NREQ-1:0] v, int p);
      logic [NREQ-1:0] r;
      r = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (r == '0 && v[(p + k) % NREQ]) r[(p + k) % NREQ] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [W:0] exact_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
      return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
   endfunction

   // Result as seen through the slice in use (approximate slice zeroes bit 0
   // of every 5-bit chunk but leaves the carries alone)
   function automatic logic [W:0] ref_add(logic [W-1:0] a, logic [W-1:0] b, logic c);
      logic [W:0] r;
      r = exact_add(a, b, c);
`ifdef ADDER_SLICE_ERR_MON_EN
      for (int k = 0; k < NSLICE; k++) r[5*k] = 1'b0;
`endif
      return r;
   endfunction

   // Carry into chunk k: carry out of the low 5*k bits of a+b+c
   function automatic logic carry_into(logic [W-1:0] a, logic [W-1:0] b, logic c, int k);
      logic [W:0] m;
      logic [W:0] s;
      if (k == 0) return c;
      m = ({{W{1'b0}}, 1'b1} << (5*k)) - 1'b1;
      s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
      return s[5*k];
   endfunction

   // Arbitration / timing monitor: predicts req_ready, rsp_valid and slice
   // operands, and pushes the expected response on every accept
   always @(negedge clk) begin : acc_mon
      logic [NREQ-1:0] er;
      logic [W:0]      r;
      exp_t            e;
      int              g;
      if (!rst_n) begin
         if (rstchk) begin
            chk("rst req_ready", 64'(bus.req_ready), 64'(0));
            chk("rst rsp_valid", 64'(bus.rsp_valid), 64'(0));
            chk("rst rsp_id",    64'(bus.rsp_id),    64'(0));
            chk("rst rsp_sum",   64'(bus.rsp_sum),   64'(0));
            chk("rst rsp_cout",  64'(bus.rsp_cout),  64'(0));
            chk("rst sl_a",      64'(sl_a),          64'(0));
            chk("rst sl_b",      64'(sl_b),          64'(0));
            chk("rst sl_cin",    64'(sl_cin),        64'(0));
`ifdef ADDER_SLICE_ERR_MON_EN
            chk("rst err_cnt",   64'(err_cnt),       64'(0));
`endif
         end
         ph    = 0;
         run_k = 0;
         rr_m  = 0;
         sbq.delete();
      end else begin
         er = (ph == 0) ? rr_pick(bus.req_valid, rr_m) : '0;
         chk("req_ready", 64'(bus.req_ready), 64'(er));
         chk("rsp_valid", 64'(bus.rsp_valid), 64'(ph == 2));
         if (ph == 1) begin
            chk("sl_a",   64'(sl_a),   64'((cur_a >> (5*run_k)) & W'(31)));
            chk("sl_b",   64'(sl_b),   64'((cur_b >> (5*run_k)) & W'(31)));
            chk("sl_cin", 64'(sl_cin), 64'(carry_into(cur_a, cur_b, cur_cin, run_k)));
         end else begin
            chk("sl_a idle",   64'(sl_a),   64'(0));
            chk("sl_b idle",   64'(sl_b),   64'(0));
            chk("sl_cin idle", 64'(sl_cin), 64'(0));
         end
         case (ph)
            0: begin
               if ((bus.req_valid & er) != '0) begin
                  g = 0;
                  for (int k = 0; k < NREQ; k++) if (er[k]) g = k;
                  cur_a   = bus.req_a[g*W +: W];
                  cur_b   = bus.req_b[g*W +: W];
                  cur_cin = bus.req_cin[g];
                  r       = ref_add(cur_a, cur_b, cur_cin);
                  e.id    = g;
                  e.sum   = r[W-1:0];
                  e.cout  = r[W];
                  e.err   = (r != exact_add(cur_a, cur_b, cur_cin));
                  sbq.push_back(e);
                  rr_m  = (g + 1) % NREQ;
                  acc_cnt++;
                  ph    = 1;
                  run_k = 0;
               end
            end
            1: begin
               run_k++;
               if (run_k == NSLICE) ph = 2;
            end
            default: if (bus.rsp_ready) ph = 0;
         endcase
      end
   end

   // Response monitor: compares every presented response with the scoreboard
   always @(negedge clk) begin : rsp_mon
      exp_t e;
      if (!rst_n) begin
         err_m = 0;
      end else if (bus.rsp_valid) begin
         if (sbq.size() == 0) begin
            chk("rsp unexpected", 64'(bus.rsp_valid), 64'(0));
         end else begin
            e = sbq[0];
            chk("rsp_id",   64'(bus.rsp_id),   64'(e.id));
            chk("rsp_sum",  64'(bus.rsp_sum),  64'(e.sum));
            chk("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
`ifdef ADDER_SLICE_ERR_MON_EN
            chk("rsp_err",  64'(rsp_err),      64'(e.err));
            chk("err_cnt",  64'(err_cnt),      64'(err_m));
`endif
            if (dir_en) begin
               chk("dir rsp_sum",  64'(bus.rsp_sum),  64'(dir_sum));
               chk("dir rsp_cout", 64'(bus.rsp_cout), 64'(dir_cout));
            end
            if (bus.rsp_ready) begin
               $display("rsp id=%0d sum=%05h cout=%0d", bus.rsp_id, bus.rsp_sum, bus.rsp_cout);
               void'(sbq.pop_front());
               rsp_cnt++;
               if (e.err && err_m < 65535) err_m++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic timeout(string nm);
      $display("FAIL timeout %s: got no event want event", nm);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   endtask

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      tick();
      rstchk = 1'b1;
      tick();
      rstchk = 1'b0;
      rst_n  = 1'b1;
   endtask

   task automatic set_op(int i, logic [W-1:0] a, logic [W-1:0] b, logic c);
      bus.req_a[i*W +: W] = a;
      bus.req_b[i*W +: W] = b;
      bus.req_cin[i]      = c;
      bus.req_valid[i]    = 1'b1;
      $display("req %0d a=%05h b=%05h cin=%0d", i, a, b, c);
   endtask

   task automatic wait_accept(logic [NREQ-1:0] m);
      logic [NREQ-1:0] pend;
      logic [NREQ-1:0] acc;
      int n;
      pend = m;
      n    = 0;
      while (pend != '0) begin
         @(negedge clk);
         acc = bus.req_valid & bus.req_ready & pend;
         tick();
         for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
               bus.req_valid[k] = 1'b0;
               pend[k]          = 1'b0;
            end
         end
         if (rand_bp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
         n++;
         if (n > 300) timeout("accept");
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(ph == 0 && sbq.size() == 0)) begin
         tick();
         if (rand_bp) bus.rsp_ready = ($urandom_range(0, 3) != 0);
         n++;
         if (n > 300) timeout("idle");
      end
      bus.rsp_ready = 1'b1;
   endtask

   initial begin
      int n;
      int base;
      logic [NREQ-1:0] m;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = '0;
      bus.rsp_ready = 1'b1;
      do_reset();

      // Single operation
`ifndef ADDER_SLICE_ERR_MON_EN
      dir_sum  = 20'h1CF12;
      dir_cout = 1'b0;
      dir_en   = 1'b1;
`endif
      set_op(0, 20'h12345, 20'h0ABCD, 1'b0);
      wait_accept(2'b01);
      wait_idle();
      dir_en = 1'b0;

      // Full carry ripple
      dir_sum  = 20'h00000;
      dir_cout = 1'b1;
      dir_en   = 1'b1;
      set_op(0, 20'hFFFFF, 20'h00001, 1'b0);
      wait_accept(2'b01);
      wait_idle();
      dir_en = 1'b0;

      // Round robin from reset with both requesters held valid
      do_reset();
      set_op(0, 20'd1, 20'd1, 1'b0);
      set_op(1, 20'd1, 20'd1, 1'b0);
      base = acc_cnt;
      n    = 0;
      while (acc_cnt < base + 4) begin
         tick();
         n++;
         if (n > 300) timeout("round robin");
      end
      bus.req_valid = '0;
      wait_idle();

      // Backpressure in DONE with a second request waiting
      bus.rsp_ready = 1'b0;
      set_op(0, W'($urandom), W'($urandom), 1'b1);
      wait_accept(2'b01);
      set_op(1, W'($urandom), W'($urandom), 1'b0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n > 50) timeout("rsp_valid");
      end while (!bus.rsp_valid);
      repeat (3) tick();
      bus.rsp_ready = 1'b1;
      wait_accept(2'b10);
      wait_idle();

      // Reset in the middle of RUN (idx=2), then a clean operation
      set_op(0, 20'h54321, 20'h11111, 1'b1);
      wait_accept(2'b01);
      tick();
      tick();
      do_reset();
      set_op(1, 20'h0F0F0, 20'h00F0F, 1'b1);
      wait_accept(2'b10);
      wait_idle();

      // Error-monitor style operands (exact in the default build)
      set_op(0, 20'd1, 20'd0, 1'b0);
      wait_accept(2'b01);
      wait_idle();
      set_op(0, 20'd2, 20'd2, 1'b0);
      wait_accept(2'b01);
      wait_idle();

      // Randomized traffic with random backpressure
      rand_bp = 1'b1;
      for (int t = 0; t < 40; t++) begin
         m = NREQ'($urandom_range(1, 3));
         for (int k = 0; k < NREQ; k++) begin
            if (m[k]) set_op(k, W'($urandom), W'($urandom), 1'($urandom));
         end
         wait_accept(m);
      end
      wait_idle();
      rand_bp = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
